// File: rtl/hack_screen_scanner_pkg.sv
// Shared constants and state encoding for the Hack screen scanner.
// Screen geometry matches the Hack platform memory map.
package hack_screen_pkg;
  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 15;
  localparam int SCREEN_BASE  = 16384;
  localparam int SCREEN_WORDS = 8192;
  localparam int SCREEN_WPL   = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;
endpackage

// File: rtl/hack_screen_scanner_if.sv
// Control, RAM read port and pixel stream of the screen scanner.
// master = scanner side, slave = RAM/consumer/controller side.
interface hack_screen_scanner_if
  import hack_screen_pkg::*;
#(
  parameter int DATA = DATA_W,
  parameter int ADDR = ADDR_W
);
  logic            start;
  logic            busy;
  logic            done;
  logic [ADDR-1:0] m_addr;
  logic            m_rd;
  logic [DATA-1:0] m_din;
  logic            px;
  logic            px_valid;
  logic            px_ready;
  logic            px_first;
  logic            px_eol;
  logic            px_last;

  modport master (
    input  start, m_din, px_ready,
    output busy, done, m_addr, m_rd,
    output px, px_valid, px_first, px_eol, px_last
  );

  modport slave (
    output start, m_din, px_ready,
    input  busy, done, m_addr, m_rd,
    input  px, px_valid, px_first, px_eol, px_last
  );
endinterface

// File: rtl/hack_screen_scanner_word_skid_buffer.sv
// Two-entry word FIFO between the RAM read port and the serializer.
// The caller guarantees no push at count=2 and no pop at count=0.
module word_skid_buffer
  import hack_screen_pkg::*;
#(
  parameter int DATA = DATA_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic [DATA-1:0] i_din,
  input  logic            i_pop,
  output logic [1:0]      o_count,
  output logic [DATA-1:0] o_head
);
  logic [DATA-1:0] r_mem [2];
  logic            r_wr;
  logic            r_rd;
  logic [1:0]      r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= ~r_wr;
      end
      if (i_pop) begin
        r_rd <= ~r_rd;
      end
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/hack_screen_scanner.sv
// Walks the Hack screen region and serializes it into a pixel stream.
// Reads are credit-limited so the 2-word buffer can never overflow.
module hack_screen_scanner
  import hack_screen_pkg::*;
#(
  parameter int DATA  = DATA_W,
  parameter int ADDR  = ADDR_W,
  parameter int BASE  = SCREEN_BASE,
  parameter int WORDS = SCREEN_WORDS,
  parameter int WPL   = SCREEN_WPL
) (
  input  logic                  a_clk,
  input  logic                  a_rst_n,
  hack_screen_scanner_if.master bus
);
  localparam int CW = $clog2(WORDS) + 1;
  localparam int BW = $clog2(DATA);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_fetch_idx;
  logic [CW-1:0]   r_out_idx;
  logic [BW-1:0]   r_bit;
  logic            r_inflight;
  logic            r_done;

  logic [1:0]      w_count;
  logic [DATA-1:0] w_head;
  logic            w_accept;
  logic            w_credit;
  logic            w_rd;
  logic            w_valid;
  logic            w_hs;
  logic            w_bit_end;
  logic            w_pop;
  logic            w_last;
  logic            w_eol;

  word_skid_buffer #(
    .DATA (DATA)
  ) u_buf (
    .i_clk   (a_clk),
    .i_rst_n (a_rst_n),
    .i_push  (r_inflight),
    .i_din   (bus.m_din),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // A start landing on the done cycle belongs to the finished frame.
  assign w_accept  = (r_state == IDLE) && bus.start && !r_done;
  assign w_credit  = (w_count == 2'd0) ||
                     ((w_count == 2'd1) && !r_inflight);
  assign w_rd      = (r_state == FETCH) && w_credit;
  assign w_valid   = (w_count != 2'd0);
  assign w_hs      = w_valid && bus.px_ready;
  assign w_bit_end = (r_bit == BW'(DATA - 1));
  assign w_pop     = w_hs && w_bit_end;
  assign w_last    = w_bit_end && (r_out_idx == CW'(WORDS - 1));
  assign w_eol     = w_bit_end &&
                     ((r_out_idx % CW'(WPL)) == CW'(WPL - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = FETCH;
      end
      FETCH: begin
        if (w_rd && (r_fetch_idx == CW'(WORDS - 1)))
          w_next = DRAIN;
      end
      DRAIN: begin
        if (w_hs && w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_state     <= IDLE;
      r_fetch_idx <= '0;
      r_out_idx   <= '0;
      r_bit       <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rd;
      r_done     <= w_hs && w_last;
      if (w_accept) begin
        r_fetch_idx <= '0;
        r_out_idx   <= '0;
        r_bit       <= '0;
      end else begin
        if (w_rd) r_fetch_idx <= r_fetch_idx + 1'b1;
        if (w_hs) begin
          r_bit <= r_bit + 1'b1;
          if (w_bit_end) r_out_idx <= r_out_idx + 1'b1;
        end
      end
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
  assign bus.m_rd     = w_rd;
  assign bus.m_addr   = w_rd ? (ADDR'(BASE) + ADDR'(r_fetch_idx))
                             : '0;
  assign bus.px_valid = w_valid;
  assign bus.px       = w_valid && w_head[r_bit];
  assign bus.px_first = w_valid && (r_out_idx == '0) &&
                        (r_bit == '0);
  assign bus.px_eol   = w_valid && w_eol;
  assign bus.px_last  = w_valid && w_last;
endmodule

// File: tb/tb_hack_screen_scanner.sv
// Randomized bench for hack_screen_scanner with a pixel-index model.
// A reduced frame size keeps whole-frame runs short.
module tb_hack_screen_scanner;
  import hack_screen_pkg::*;

  localparam int W    = 128;
  localparam int WPLN = SCREEN_WPL;
  localparam int BA   = SCREEN_BASE;
  localparam int NPX  = W * 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hack_screen_scanner_if bus();

  hack_screen_scanner #(
    .WORDS (W)
  ) dut (
    .a_clk   (clk),
    .a_rst_n (rst_n),
    .bus     (bus)
  );

  logic [15:0] mem [0:32767];

  always @(posedge clk) bus.m_din <= mem[bus.m_addr];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: pixel k of a frame is bit k%16 of word BA+k/16.
  int   k = 0;
  int   issued = 0;
  int   frames = 0;
  int   eol_seen = 0;
  int   last_seen = 0;
  bit   exp_busy = 0;
  bit   exp_done = 0;
  bit   prev_hold = 0;
  bit   hs;
  logic [15:0] wv;
  logic [3:0]  exp_mk;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outs",
          {bus.busy, bus.done, bus.m_rd, bus.px, bus.px_valid,
           bus.px_first, bus.px_eol, bus.px_last}, 0);
      chk("rst_addr", bus.m_addr, 0);
      k = 0;
      issued = 0;
      exp_busy = 0;
      exp_done = 0;
      prev_hold = 0;
    end else begin
      chk("busy", bus.busy, exp_busy);
      chk("done", bus.done, exp_done);
      if (bus.m_rd) begin
        chk("m_addr", bus.m_addr, BA + issued);
        chk("credit", (issued - (k / 16)) < 2, 1);
        chk("rd_in_frame", exp_busy && (issued < W), 1);
        issued++;
      end
      if (prev_hold) chk("hold_valid", bus.px_valid, 1);
      if (bus.px_valid) begin
        chk("valid_in_frame", exp_busy && (k < NPX), 1);
        if (k < NPX) begin
          wv = mem[BA + k / 16];
          exp_mk = {wv[k % 16], k == 0,
                    (k % 16 == 15) && ((k / 16) % WPLN == WPLN - 1),
                    k == NPX - 1};
          chk("px_markers",
              {bus.px, bus.px_first, bus.px_eol, bus.px_last},
              exp_mk);
        end
      end
      hs = bus.px_valid && bus.px_ready;
      prev_hold = bus.px_valid && !bus.px_ready;
      exp_done = 0;
      if (hs) begin
        if (bus.px_eol) eol_seen++;
        if (bus.px_last) last_seen++;
        k++;
        if (k == NPX) begin
          exp_busy = 0;
          exp_done = 1;
          frames++;
        end
      end else if (bus.start && !exp_busy && !bus.done) begin
        exp_busy = 1;
        k = 0;
        issued = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input int mode,
                           output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done) begin
        at = cyc;
        break;
      end
      bus.px_ready = (mode == 0) ? 1'b1
                   : ($urandom_range(0, 9) >= 3);
    end
    bus.px_ready = 1'b1;
    chk("frame_done_in_budget", at != -1, 1);
  endtask

  int c0;
  int at;
  int f0;

  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = 16'h0000;
    mem[BA] = 16'h0001;
    bus.start = 1'b0;
    bus.px_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single set pixel, exact latency, markers and done timing.
    eol_seen = 0;
    last_seen = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    c0 = cyc;
    chk("t1_busy", bus.busy, 1);
    chk("t1_m_rd", bus.m_rd, 1);
    chk("t1_m_addr", bus.m_addr, 16384);
    tick();
    chk("t1_no_px_yet", bus.px_valid, 0);
    tick();
    chk("t1_first_px", {bus.px_valid, bus.px, bus.px_first}, 3'b111);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("t1_zero_px", {bus.px_valid, bus.px, bus.px_first}, 3'b100);
    end
    wait_done(NPX + 100, 0, at);
    chk("t1_done_cycle", at - c0, 2050);
    chk("t1_busy_at_done", bus.busy, 0);
    chk("t1_eol_count", eol_seen, 4);
    chk("t1_last_count", last_seen, 1);
    chk("t1_pixels", k, 2048);
    chk("t1_frames", frames, 1);

    // Random image, random back-pressure.
    for (int a = 0; a < W; a++) mem[BA + a] = 16'($urandom);
    eol_seen = 0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(NPX * 4, 1, at);
    chk("t3_eol_count", eol_seen, W / WPLN);
    chk("t3_frames", frames, 2);

    // Long stall on the very first pixel.
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10 && !bus.px_valid; i++) tick();
    chk("t4_valid_seen", bus.px_valid, 1);
    bus.px_ready = 1'b0;
    repeat (100) tick();
    chk("t4_frozen", {bus.px_valid, bus.px_first}, 2'b11);
    chk("t4_reads_held", issued, 2);
    wait_done(NPX * 2, 0, at);
    chk("t4_frames", frames, 3);

    // Asynchronous reset mid-frame, then a clean rescan.
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 1500 && k < 1000; i++) tick();
    chk("t5_mid_frame", k >= 1000, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_zero",
        {bus.busy, bus.m_rd, bus.px, bus.px_valid,
         bus.px_first, bus.px_eol, bus.px_last}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t5_rescan_addr", bus.m_addr, 16384);
    tick();
    tick();
    chk("t5_rescan_first", {bus.px_valid, bus.px_first}, 2'b11);
    wait_done(NPX * 4, 1, at);
    chk("t5_frames", frames, 4);

    // Starts while busy and on the done cycle are ignored.
    f0 = frames;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    at = -1;
    for (int i = 0; i < NPX + 100; i++) begin
      tick();
      bus.start = 1'b0;
      if (bus.done) begin
        at = cyc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        break;
      end
      if (i % 300 == 50) bus.start = 1'b1;
    end
    chk("t6_done_seen", at != -1, 1);
    repeat (40) tick();
    chk("t6_idle_after", bus.busy, 0);
    chk("t6_one_frame", frames, f0 + 1);
    chk("t6_no_new_reads", issued, W);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
